// File: rtl/dmem_responder.sv
// Memory-side responder for the data-memory req/gnt/rvalid bus, backed by an internal word RAM.
// Optional macro DMEM_RESP_ERR_EN enables error responses for out-of-range or misaligned requests.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
    parameter int unsigned RD_LATENCY  = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic [6:0]  data_rdata_intg_o,
    output logic        data_err_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             we_q;
    logic             err_q;
    logic [31:0]      rdata_q;
    logic [31:0]      offset;
    logic [IDX_W-1:0] idx;
    logic             req_err;
    logic             grant;

    logic [31:0] mem [DEPTH_WORDS];

    assign offset = data_addr_i - BASE_ADDR;
    assign idx    = offset[IDX_W+1:2];

`ifdef DMEM_RESP_ERR_EN
    localparam logic [33:0] SPAN = 34'(DEPTH_WORDS) << 2;

    // The explicit lower-bound test catches wrapped offsets when addr < BASE_ADDR.
    assign req_err = (data_addr_i < BASE_ADDR) || ({2'b00, offset} >= SPAN) ||
                     (data_addr_i[1:0] != 2'b00);
`else
    logic unused_offset;

    assign req_err       = 1'b0;
    assign unused_offset = ^{offset[31:IDX_W+2], offset[1:0]};
`endif

    assign grant = (state_q == StIdle) && data_req_i;

    always_ff @(posedge clk_i) begin
        if (grant && data_we_i && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (grant) begin
                    if (RD_LATENCY == 1) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(RD_LATENCY - 1);
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (grant) begin
                we_q    <= data_we_i;
                err_q   <= req_err;
                rdata_q <= mem[idx];
            end
        end
    end

    assign data_gnt_o        = grant;
    assign data_rvalid_o     = (state_q == StResp);
    assign data_rdata_o      = (data_rvalid_o && !we_q && !err_q) ? rdata_q : 32'h0;
    assign data_rdata_intg_o = 7'h0;
    assign data_err_o        = data_rvalid_o && err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: one instance at RD_LATENCY=1, one at RD_LATENCY=3.
// Expected responses come from a word model and are queued at grant, popped at rvalid.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0010_0000;

    logic clk_i = 1'b0;
    logic rst_ni;

    logic        req    [2];
    logic        we     [2];
    logic [3:0]  be     [2];
    logic [31:0] addr   [2];
    logic [31:0] wdata  [2];
    logic        gnt    [2];
    logic        rvalid [2];
    logic [31:0] rdata  [2];
    logic [6:0]  intg   [2];
    logic        err    [2];

    int checks = 0;
    int errors = 0;

    logic [31:0] model [int];
    logic [32:0] sbq [$];

    always #5 clk_i = ~clk_i;

    dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE),
        .RD_LATENCY (1)
    ) u_dut0 (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .data_req_i       (req[0]),
        .data_we_i        (we[0]),
        .data_be_i        (be[0]),
        .data_addr_i      (addr[0]),
        .data_wdata_i     (wdata[0]),
        .data_gnt_o       (gnt[0]),
        .data_rvalid_o    (rvalid[0]),
        .data_rdata_o     (rdata[0]),
        .data_rdata_intg_o(intg[0]),
        .data_err_o       (err[0])
    );

    dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE),
        .RD_LATENCY (3)
    ) u_dut1 (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .data_req_i       (req[1]),
        .data_we_i        (we[1]),
        .data_be_i        (be[1]),
        .data_addr_i      (addr[1]),
        .data_wdata_i     (wdata[1]),
        .data_gnt_o       (gnt[1]),
        .data_rvalid_o    (rvalid[1]),
        .data_rdata_o     (rdata[1]),
        .data_rdata_intg_o(intg[1]),
        .data_err_o       (err[1])
    );

    function automatic logic exp_err(input logic [31:0] a);
`ifdef DMEM_RESP_ERR_EN
        return (a < BASE) || (a >= BASE + 32'(4 * DEPTH)) || (a[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int key_of(input int d, input logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE) >> 2;
        return d * 65536 + int'(off & 32'(DEPTH - 1));
    endfunction

    // Drives one request, pushes the expected response at grant, then checks the response.
    task automatic access(input int d, input logic w, input logic [3:0] b, input logic [31:0] a,
                          input logic [31:0] wd, input string name);
        int          lat;
        int          cyc;
        int          k;
        logic        e;
        logic [31:0] word;
        logic [32:0] exp;
        lat  = (d == 0) ? 1 : 3;
        e    = exp_err(a);
        k    = key_of(d, a);
        word = model.exists(k) ? model[k] : 32'h0;
        req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd;
        #1;
        checks++;
        if (gnt[d] !== 1'b1) begin
            errors++;
            $display("FAIL %s gnt: got %b want 1", name, gnt[d]);
        end
        sbq.push_back({e, (w || e) ? 32'h0 : word});
        if (w && !e) begin
            for (int n = 0; n < 4; n++) if (b[n]) word[8*n +: 8] = wd[8*n +: 8];
            model[k] = word;
        end
        @(posedge clk_i); #1;
        req[d] = 1'b0;
        cyc = 1;
        while (rvalid[d] !== 1'b1 && cyc < 32) begin
            @(posedge clk_i); #1;
            cyc++;
        end
        exp = sbq.pop_front();
        checks++;
        if (cyc != lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc, lat);
        end
        checks++;
        if (rdata[d] !== exp[31:0]) begin
            errors++;
            $display("FAIL %s rdata: got %h want %h", name, rdata[d], exp[31:0]);
        end
        checks++;
        if (err[d] !== exp[32]) begin
            errors++;
            $display("FAIL %s err: got %b want %b", name, err[d], exp[32]);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({gnt[d], rvalid[d], err[d], rdata[d], intg[d]} !== 42'h0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got gnt=%b rvalid=%b err=%b rdata=%h intg=%h want 0",
                         d, gnt[d], rvalid[d], err[d], rdata[d], intg[d]);
            end
        end
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        checks++;
        if (rvalid[0] !== 1'b0 || rvalid[1] !== 1'b0) begin
            errors++;
            $display("FAIL reset_release rvalid: got %b%b want 00", rvalid[0], rvalid[1]);
        end
    endtask

    task automatic test_write_read();
        access(0, 1'b1, 4'hF, 32'h0010_0008, 32'hDEAD_BEEF, "wr_deadbeef");
        access(0, 1'b0, 4'hF, 32'h0010_0008, 32'h0, "rd_deadbeef");
        checks++;
        if (model[key_of(0, 32'h0010_0008)] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL model_deadbeef: got %h want deadbeef", model[key_of(0, 32'h0010_0008)]);
        end
    endtask

    task automatic test_byte_enables();
        access(0, 1'b1, 4'hF, 32'h0010_0010, 32'h1122_3344, "be_init");
        access(0, 1'b1, 4'b0101, 32'h0010_0010, 32'hAABB_CCDD, "be_0101_wr");
        access(0, 1'b0, 4'hF, 32'h0010_0010, 32'h0, "be_0101_rd");
        access(0, 1'b1, 4'b0000, 32'h0010_0010, 32'hFFFF_FFFF, "be_0000_wr");
        access(0, 1'b0, 4'hF, 32'h0010_0010, 32'h0, "be_0000_rd");
        access(1, 1'b1, 4'b1010, 32'h0010_0010, 32'h5566_7788, "be_1010_lat3_wr");
        access(1, 1'b0, 4'hF, 32'h0010_0010, 32'h0, "be_1010_lat3_rd");
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [32:0] exp;
        int          k;
        for (int i = 0; i < 3; i++) begin
            access(1, 1'b1, 4'hF, 32'h0010_0020 + 32'(4 * i), $urandom, "b2b_preload");
        end
        k = 0;
        a = 32'h0010_0020;
        req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = a;
        for (int c = 0; c < 12; c++) begin
            #1;
            checks++;
            if (gnt[1] !== ((c % 4) == 0)) begin
                errors++;
                $display("FAIL b2b gnt c=%0d: got %b want %b", c, gnt[1], (c % 4) == 0);
            end
            checks++;
            if (rvalid[1] !== ((c % 4) == 3)) begin
                errors++;
                $display("FAIL b2b rvalid c=%0d: got %b want %b", c, rvalid[1], (c % 4) == 3);
            end
            if (gnt[1] === 1'b1) sbq.push_back({1'b0, model[key_of(1, a)]});
            if (rvalid[1] === 1'b1 && sbq.size() > 0) begin
                exp = sbq.pop_front();
                checks++;
                if (rdata[1] !== exp[31:0]) begin
                    errors++;
                    $display("FAIL b2b rdata c=%0d: got %h want %h", c, rdata[1], exp[31:0]);
                end
            end
            @(posedge clk_i); #1;
            if ((c % 4) == 0) begin
                k++;
                a = 32'h0010_0020 + 32'(4 * k);
                addr[1] = a;
            end
            if (c == 11) req[1] = 1'b0;
        end
        sbq.delete();
    endtask

    task automatic test_reset_mid();
        int seen;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0010_0020;
        #1;
        checks++;
        if (gnt[1] !== 1'b1) begin
            errors++;
            $display("FAIL midrst gnt: got %b want 1", gnt[1]);
        end
        @(posedge clk_i); #1;
        req[1] = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        seen = 0;
        repeat (2) begin
            @(posedge clk_i); #1;
            if (rvalid[1] !== 1'b0) seen++;
        end
        rst_ni = 1'b1;
        repeat (6) begin
            @(posedge clk_i); #1;
            if (rvalid[1] !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midrst rvalid_cycles: got %0d want 0", seen);
        end
        access(1, 1'b0, 4'hF, 32'h0010_0020, 32'h0, "midrst_after");
    endtask

    task automatic test_err();
        for (int d = 0; d < 2; d++) begin
            access(d, 1'b1, 4'hF, 32'h0010_0000, 32'hCAFE_0000 + 32'(d), "err_preload");
            access(d, 1'b1, 4'hF, 32'h0000_0000, 32'h1357_9BDF, "err_wr_low");
            access(d, 1'b0, 4'hF, 32'h0010_0000, 32'h0, "err_ram_check");
            access(d, 1'b0, 4'hF, 32'h0010_0002, 32'h0, "err_rd_misaligned");
            access(d, 1'b0, 4'hF, BASE + 32'(4 * DEPTH), 32'h0, "err_rd_past_end");
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; be[d] = 4'h0; addr[d] = 32'h0; wdata[d] = 32'h0;
        end
        test_reset();
        test_write_read();
        test_byte_enables();
        test_back_to_back();
        test_reset_mid();
        test_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
